stream_src: RTL and testbench
=============================

// Module: stream_src
//
// PURPOSE
//  Frame-structured stream transmitter that drives the up_data/up_val input of
//  delay_mem and the other stream-filter stages. Emits a raster of cfg_width x
//  cfg_height samples with cfg_gap idle cycles between lines. Marks line/frame
//  ends. Serves as the production stimulus source and the bench source.
//
// PARAMETERS
//  IMG_WIDTH   8   sample width (bits) of dn_data
//  CNT_WIDTH   8   width of cfg_width/cfg_height/cfg_gap and internal counters
//
// PORTS
//  clk         in   1          clock, all logic on rising edge
//  rst_n       in   1          reset, asynchronous, active-low
//  cfg_width   in   CNT_WIDTH  samples per line
//  cfg_height  in   CNT_WIDTH  lines per frame
//  cfg_gap     in   CNT_WIDTH  idle cycles between consecutive lines
//  cfg_set     in   1          capture cfg_* into internal registers
//  start       in   1          begin one frame
//  halt        in   1          abort the current frame
//  dn_data     out  IMG_WIDTH  sample value
//  dn_val      out  1          dn_data valid, no backpressure
//  dn_eol      out  1          last sample of a line (qualified by dn_val)
//  dn_eof      out  1          last sample of a frame (qualified by dn_val)
//  busy        out  1          frame in progress
//
// BEHAVIOUR
//  - All outputs are registered and reset to 0. Config registers reset to 0.
//  - FSM states: IDLE, LINE, GAP.
//  - cfg_set is honoured only in IDLE. It is ignored while busy.
//  - If cfg_set and start occur in the same cycle, the new cfg applies to
//    that frame.
//  - start in IDLE with width!=0 and height!=0:
//    - goes to LINE; busy=1 next cycle.
//    - first dn_val is 1 cycle after start.
//  - start with width or height 0 is ignored. start while busy is ignored.
//  - LINE: one sample per cycle, dn_val=1.
//    - dn_data starts at 1 each frame and increments by 1 per sample.
//    - dn_data wraps 2^IMG_WIDTH-1 -> 0.
//    - On sample cfg_width of a line: dn_eol=1.
//      - If the line is not the last and gap>0: go to GAP.
//      - If the line is not the last and gap=0: next line starts the
//        following cycle, with no bubble.
//      - On the last line, dn_eof=1 together with dn_eol; go to IDLE.
//      - busy=0 in the cycle after the eof sample.
//  - GAP: dn_val=0 for exactly cfg_gap cycles, then LINE.
//  - halt (any state): next cycle IDLE, dn_val/dn_eol/dn_eof/busy=0. No eof
//    is emitted for the aborted frame. halt has priority over start.
//  - Width/height at max (2^CNT_WIDTH-1) must work: counters compare, no
//    overflow.
//  - rst_n low at any time: immediate return to IDLE, outputs 0.
//  - Frame length in cycles = H*W + (H-1)*G.
//
// TESTING
//  1. Reset, cfg W=4 H=3 G=2, start
//     -> data 1..12 valid. eol at 4/8/12; eof only at 12.
//     -> 2 idle cycles after 4 and after 8. busy spans 16 cycles.
//  2. W=5 H=2 G=0 -> 10 consecutive valid cycles, eol at 5 and 10, eof at 10.
//  3. W=255 H=2 G=0, IMG_WIDTH=8
//     -> data wraps 255->0 at sample 256.
//     -> 510 samples total; eol at 255 and 510.
//  4. start with H=0; cfg_set/start while busy
//     -> no output; running frame unchanged; new cfg is not applied.
//  5. halt mid-line (sample 3 of line 2)
//     -> dn_val=0 and busy=0 next cycle.
//     -> restart: data begins at 1.
//  6. rst_n pulsed low mid-GAP
//     -> outputs 0 asynchronously; cfg cleared; start ignored until cfg_set.

Source files
------------

// File: rtl/stream_src_if.sv
// Downstream sample stream produced by stream_src.
// Handshake: dn_val marks a valid dn_data beat. There is no ready signal, so the
// consumer must accept every beat on which dn_val is high. dn_eol and dn_eof
// carry meaning only on cycles where dn_val is high.
interface stream_src_if #(
   parameter int IMG_WIDTH = 8
);
   logic [IMG_WIDTH-1:0] dn_data;
   logic                 dn_val;
   logic                 dn_eol;
   logic                 dn_eof;

   modport master (output dn_data, output dn_val, output dn_eol, output dn_eof);
   modport slave  (input  dn_data, input  dn_val, input  dn_eol, input  dn_eof);
endinterface

// File: rtl/stream_src.sv
// Frame-structured raster source: cfg_width x cfg_height samples per frame, with
// cfg_gap idle cycles between lines. The data value counts up from 1 each frame.
// The state register reads LINE for every cycle in which a sample is on the
// outputs, GAP during inter-line idle cycles, and IDLE otherwise.
module stream_src #(
   parameter int IMG_WIDTH = 8,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [CNT_WIDTH-1:0] cfg_width,
   input  logic [CNT_WIDTH-1:0] cfg_height,
   input  logic [CNT_WIDTH-1:0] cfg_gap,
   input  logic                 cfg_set,
   input  logic                 start,
   input  logic                 halt,
   stream_src_if.master         dn,
   output logic                 busy,
   output logic [1:0]           dbg_state
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LINE = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [IMG_WIDTH-1:0] DAT_ONE  = {{(IMG_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]           state_q, state_d;
   logic [CNT_WIDTH-1:0] cfg_w_q, cfg_w_d;
   logic [CNT_WIDTH-1:0] cfg_h_q, cfg_h_d;
   logic [CNT_WIDTH-1:0] cfg_g_q, cfg_g_d;
   logic [CNT_WIDTH-1:0] col_q, col_d;
   logic [CNT_WIDTH-1:0] row_q, row_d;
   logic [CNT_WIDTH-1:0] gap_q, gap_d;
   logic [IMG_WIDTH-1:0] data_q, data_d;
   logic                 val_q, val_d;
   logic                 eol_q, eol_d;
   logic                 eof_q, eof_d;
   logic                 busy_q, busy_d;

   // Effective geometry: a cfg_set arriving with start in IDLE applies to that frame
   logic [CNT_WIDTH-1:0] w_eff, h_eff;
   logic                 emit;
   logic [CNT_WIDTH-1:0] emit_col, emit_row;

   // Select the geometry that the next emitted sample is measured against
   always_comb begin
      w_eff = cfg_w_q;
      h_eff = cfg_h_q;
      if (state_q == ST_IDLE && cfg_set) begin
         w_eff = cfg_width;
         h_eff = cfg_height;
      end
   end

   // Next-state, counter and output computation; halt overrides everything
   always_comb begin
      state_d  = state_q;
      cfg_w_d  = cfg_w_q;
      cfg_h_d  = cfg_h_q;
      cfg_g_d  = cfg_g_q;
      col_d    = col_q;
      row_d    = row_q;
      gap_d    = gap_q;
      data_d   = data_q;
      val_d    = 1'b0;
      eol_d    = 1'b0;
      eof_d    = 1'b0;
      busy_d   = busy_q;
      emit     = 1'b0;
      emit_col = CNT_ZERO;
      emit_row = CNT_ZERO;

      case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            data_d = '0;
            if (cfg_set) begin
               cfg_w_d = cfg_width;
               cfg_h_d = cfg_height;
               cfg_g_d = cfg_gap;
            end
            if (start && w_eff != CNT_ZERO && h_eff != CNT_ZERO) begin
               emit     = 1'b1;
               emit_col = CNT_ONE;
               emit_row = CNT_ONE;
            end
         end
         ST_LINE: begin
            if (col_q != cfg_w_q) begin
               emit     = 1'b1;
               emit_col = col_q + CNT_ONE;
               emit_row = row_q;
            end else if (row_q == cfg_h_q) begin
               // eof sample has been shown for one cycle; frame is over
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               data_d  = '0;
            end else if (cfg_g_q == CNT_ZERO) begin
               emit     = 1'b1;
               emit_col = CNT_ONE;
               emit_row = row_q + CNT_ONE;
            end else begin
               state_d = ST_GAP;
               gap_d   = CNT_ONE;
            end
         end
         ST_GAP: begin
            if (gap_q == cfg_g_q) begin
               emit     = 1'b1;
               emit_col = CNT_ONE;
               emit_row = row_q + CNT_ONE;
            end else begin
               gap_d = gap_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            data_d  = '0;
         end
      endcase

      if (emit) begin
         state_d = ST_LINE;
         busy_d  = 1'b1;
         col_d   = emit_col;
         row_d   = emit_row;
         val_d   = 1'b1;
         data_d  = (state_q == ST_IDLE) ? DAT_ONE : data_q + DAT_ONE;
         eol_d   = (emit_col == w_eff);
         eof_d   = (emit_col == w_eff) && (emit_row == h_eff);
      end

      if (halt) begin
         state_d = ST_IDLE;
         busy_d  = 1'b0;
         val_d   = 1'b0;
         eol_d   = 1'b0;
         eof_d   = 1'b0;
         data_d  = '0;
      end
   end

   // State, config and output registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cfg_w_q <= '0;
         cfg_h_q <= '0;
         cfg_g_q <= '0;
         col_q   <= '0;
         row_q   <= '0;
         gap_q   <= '0;
         data_q  <= '0;
         val_q   <= 1'b0;
         eol_q   <= 1'b0;
         eof_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cfg_w_q <= cfg_w_d;
         cfg_h_q <= cfg_h_d;
         cfg_g_q <= cfg_g_d;
         col_q   <= col_d;
         row_q   <= row_d;
         gap_q   <= gap_d;
         data_q  <= data_d;
         val_q   <= val_d;
         eol_q   <= eol_d;
         eof_q   <= eof_d;
         busy_q  <= busy_d;
      end
   end

   assign dn.dn_data = data_q;
   assign dn.dn_val  = val_q;
   assign dn.dn_eol  = eol_q;
   assign dn.dn_eof  = eof_q;
   assign busy       = busy_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_stream_src.sv
// Directed bench for stream_src: raster frames compared cycle by cycle against
// an expected queue built from W/H/G, plus start/cfg/halt/reset corner cases.
module tb_stream_src;

   logic       clk;
   logic       rst_n;
   logic [7:0] cfg_width;
   logic [7:0] cfg_height;
   logic [7:0] cfg_gap;
   logic       cfg_set;
   logic       start;
   logic       halt;
   logic       busy;
   logic [1:0] dbg_state;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   // expected word per cycle: {busy, val, eol, eof, data (0 when not valid)}
   logic [11:0] exp_q[$];

   stream_src_if #(.IMG_WIDTH(8)) dn_if ();

   stream_src #(.IMG_WIDTH(8), .CNT_WIDTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_width  (cfg_width),
      .cfg_height (cfg_height),
      .cfg_gap    (cfg_gap),
      .cfg_set    (cfg_set),
      .start      (start),
      .halt       (halt),
      .dn         (dn_if),
      .busy       (busy),
      .dbg_state  (dbg_state)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [11:0] pk(input logic b, input logic v, input logic e,
                                      input logic f, input logic [7:0] d);
      return {b, v, e, f, (v ? d : 8'h00)};
   endfunction

   function automatic logic [11:0] observed();
      return pk(busy, dn_if.dn_val, dn_if.dn_eol, dn_if.dn_eof, dn_if.dn_data);
   endfunction

   // Raster reference: samples 1,2,3... with eol/eof flags and gap idle cycles,
   // optionally cut after entry halt_at, followed by one idle cycle
   task automatic build_expected(input int w, input int h, input int g, input int halt_at);
      logic [7:0] d;
      d = 8'h00;
      exp_q.delete();
      for (int r = 1; r <= h; r++) begin
         for (int c = 1; c <= w; c++) begin
            d = d + 8'h01;
            exp_q.push_back(pk(1'b1, 1'b1, c == w, (c == w) && (r == h), d));
         end
         if (r < h)
            for (int k = 0; k < g; k++) exp_q.push_back(pk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
      end
      if (halt_at >= 0)
         while (exp_q.size() > halt_at + 1) void'(exp_q.pop_back());
      exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
   endtask

   // Driver + inline per-cycle comparison. inj_at: issue cfg_set+start with a
   // different geometry while busy. halt_at: assert halt on that cycle.
   task automatic run_frame(input string name, input int w, input int h, input int g,
                            input bit do_cfg, input int inj_at, input int halt_at);
      logic [11:0] obs;
      build_expected(w, h, g, halt_at);
      @(negedge clk);
      if (do_cfg) begin
         cfg_width  = w[7:0];
         cfg_height = h[7:0];
         cfg_gap    = g[7:0];
         cfg_set    = 1'b1;
      end
      start = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      cfg_set = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         obs = observed();
         chk_cnt++;
         if (obs !== exp_q[i])
            $display("FAIL %s cycle %0d: got busy/val/eol/eof/data=%b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
                     name, i, obs[11], obs[10], obs[9], obs[8], obs[7:0],
                     exp_q[i][11], exp_q[i][10], exp_q[i][9], exp_q[i][8], exp_q[i][7:0]);
         else
            pass_cnt++;
         halt    = (i == halt_at);
         start   = (i == inj_at);
         cfg_set = (i == inj_at);
         if (i == inj_at) begin
            cfg_width  = 8'd2;
            cfg_height = 8'd1;
            cfg_gap    = 8'd0;
         end
         @(negedge clk);
      end
      halt    = 1'b0;
      start   = 1'b0;
      cfg_set = 1'b0;
   endtask

   // Check that nothing is emitted for n cycles
   task automatic expect_quiet(input string name, input int n);
      logic [11:0] obs;
      for (int i = 0; i < n; i++) begin
         obs = observed();
         chk_cnt++;
         if (obs !== 12'h000 || dbg_state !== 2'd0)
            $display("FAIL %s cycle %0d: got word=%h state=%0d want word=000 state=0",
                     name, i, obs, dbg_state);
         else
            pass_cnt++;
         start   = 1'b0;
         cfg_set = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_cnt++;
      if (observed() !== 12'h000 || dbg_state !== 2'd0)
         $display("FAIL reset: got word=%h state=%0d want word=000 state=0", observed(), dbg_state);
      else
         pass_cnt++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic_frame();
      run_frame("w4h3g2", 4, 3, 2, 1'b1, -1, -1);
   endtask

   task automatic test_back_to_back();
      run_frame("w5h2g0", 5, 2, 0, 1'b1, -1, -1);
      run_frame("w1h1g0", 1, 1, 0, 1'b1, -1, -1);
   endtask

   task automatic test_wrap();
      run_frame("w255h2", 255, 2, 0, 1'b1, -1, -1);
   endtask

   task automatic test_ignored_start();
      // zero height: start ignored
      @(negedge clk);
      cfg_width  = 8'd4;
      cfg_height = 8'd0;
      cfg_gap    = 8'd2;
      cfg_set    = 1'b1;
      start      = 1'b1;
      @(negedge clk);
      expect_quiet("h0_start", 3);
      // cfg_set/start while busy leave the frame alone
      run_frame("busy_inject", 4, 3, 2, 1'b1, 5, -1);
      // the cfg offered while busy was not captured
      run_frame("cfg_kept", 4, 3, 2, 1'b0, -1, -1);
   endtask

   task automatic test_halt();
      run_frame("halt_mid", 4, 3, 2, 1'b1, -1, 8);
      run_frame("halt_restart", 4, 1, 0, 1'b1, -1, -1);
   endtask

   task automatic test_async_reset();
      build_expected(4, 3, 2, -1);
      @(negedge clk);
      cfg_width  = 8'd4;
      cfg_height = 8'd3;
      cfg_gap    = 8'd2;
      cfg_set    = 1'b1;
      start      = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      cfg_set = 1'b0;
      repeat (4) @(negedge clk);
      chk_cnt++;
      if (dbg_state !== 2'd2 || busy !== 1'b1)
         $display("FAIL in_gap: got state=%0d busy=%b want state=2 busy=1", dbg_state, busy);
      else
         pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      chk_cnt++;
      if (observed() !== 12'h000 || dn_if.dn_data !== 8'h00 || dbg_state !== 2'd0)
         $display("FAIL async_rst: got word=%h data=%0d state=%0d want 000/0/0",
                  observed(), dn_if.dn_data, dbg_state);
      else
         pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b1;
      @(negedge clk);
      expect_quiet("start_after_rst", 3);
      run_frame("after_rst", 3, 2, 1, 1'b1, -1, -1);
   endtask

   initial begin
      rst_n      = 1'b0;
      cfg_width  = 8'd0;
      cfg_height = 8'd0;
      cfg_gap    = 8'd0;
      cfg_set    = 1'b0;
      start      = 1'b0;
      halt       = 1'b0;
      test_reset();
      test_basic_frame();
      test_back_to_back();
      test_wrap();
      test_ignored_start();
      test_halt();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
